// File: rtl/id_pipe_if.sv
// Bundle of the IF->ID handshake, writeback port, pipeline control and
// ID/EX register outputs for id_pipe.
interface id_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [31:0]       inst_in;
    logic              in_valid;
    logic              in_ready;

    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              flush;
    logic              ex_stall;

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_data_1;
    logic [DATA_W-1:0] ex_data_2;
    logic [3:0]        ex_ctl;
    logic [2:0]        m_ctl;
    logic [1:0]        wb_ctl;
    logic              ex_equal;
    logic              ex_illegal;
    logic              hazard;

    modport master (
        output inst_in, in_valid, wb_we, wb_addr, wb_data, flush, ex_stall,
        input  in_ready, ex_valid, ex_rs, ex_rt, ex_rd, ex_imm, ex_data_1,
               ex_data_2, ex_ctl, m_ctl, wb_ctl, ex_equal, ex_illegal, hazard
    );

    modport slave (
        input  inst_in, in_valid, wb_we, wb_addr, wb_data, flush, ex_stall,
        output in_ready, ex_valid, ex_rs, ex_rt, ex_rd, ex_imm, ex_data_1,
               ex_data_2, ex_ctl, m_ctl, wb_ctl, ex_equal, ex_illegal, hazard
    );
endinterface

// File: rtl/id_pipe.sv
// Instruction decode stage: register file with write-through bypass, opcode
// decode, load-use hazard detection and the ID/EX pipeline register.
module id_pipe #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int SIGN_EXT = 1
) (
    input logic      clk,
    input logic      rst_n,
    id_pipe_if.slave bus
);
    localparam int REG_AW = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef struct packed {
        logic [3:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] data_1;
        logic [DATA_W-1:0] data_2;
        ctl_t              ctl;
        logic              equal;
    } idex_t;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } action_t;

    logic [DATA_W-1:0] regs [NREG];

    logic [5:0]        opcode;
    logic [31:0]       rs_w;
    logic [31:0]       rt_w;
    logic [31:0]       rd_w;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    ctl_t              dec_ctl;
    logic              uses_rt;
    logic              load_use;
    logic              hazard;
    action_t           action;
    idex_t             idex_q;
    idex_t             idex_d;
    idex_t             load_rec;

    // Field extraction: widen first so any REG_AW truncates or zero-pads cleanly.
    assign opcode = bus.inst_in[31:26];
    assign rs_w   = 32'(bus.inst_in[25:21]);
    assign rt_w   = 32'(bus.inst_in[20:16]);
    assign rd_w   = 32'(bus.inst_in[15:11]);
    assign rs     = rs_w[REG_AW-1:0];
    assign rt     = rt_w[REG_AW-1:0];
    assign rd     = rd_w[REG_AW-1:0];

    generate
        if (SIGN_EXT != 0) begin : g_sext
            assign imm = DATA_W'($signed(bus.inst_in[15:0]));
        end else begin : g_zext
            assign imm = DATA_W'(bus.inst_in[15:0]);
        end
    endgenerate

    // Register file; writeback is independent of flush/stall/hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_we && bus.wb_addr != '0 && int'(bus.wb_addr) < NREG) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rd_data_1 = '0;
        rd_data_2 = '0;
        if (rs != '0) begin
            if (bus.wb_we && bus.wb_addr == rs) begin
                rd_data_1 = bus.wb_data;
            end else if (int'(rs) < NREG) begin
                rd_data_1 = regs[rs];
            end
        end
        if (rt != '0) begin
            if (bus.wb_we && bus.wb_addr == rt) begin
                rd_data_2 = bus.wb_data;
            end else if (int'(rt) < NREG) begin
                rd_data_2 = regs[rt];
            end
        end
    end

    always_comb begin
        dec_ctl = '0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_ctl.ex = 4'b1100;
                dec_ctl.m  = 3'b000;
                dec_ctl.wb = 2'b10;
            end
            OP_LW: begin
                dec_ctl.ex = 4'b0001;
                dec_ctl.m  = 3'b010;
                dec_ctl.wb = 2'b11;
            end
            OP_SW: begin
                dec_ctl.ex = 4'b0001;
                dec_ctl.m  = 3'b001;
                dec_ctl.wb = 2'b00;
            end
            OP_BEQ: begin
                dec_ctl.ex = 4'b0010;
                dec_ctl.m  = 3'b100;
                dec_ctl.wb = 2'b00;
            end
            default: begin
                dec_ctl.illegal = 1'b1;
            end
        endcase
    end

    // Only R-type, store and branch actually consume rt as a source operand.
    always_comb begin
        uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
        load_use = idex_q.valid && idex_q.ctl.m[1] && (idex_q.rt != '0) && bus.in_valid
                   && ((idex_q.rt == rs) || ((idex_q.rt == rt) && uses_rt));
        hazard   = load_use && !bus.flush && !bus.ex_stall;
    end

    always_comb begin
        action = ACT_BUBBLE;
        if (bus.flush) begin
            action = ACT_BUBBLE;
        end else if (bus.ex_stall) begin
            action = ACT_HOLD;
        end else if (hazard) begin
            action = ACT_BUBBLE;
        end else if (bus.in_valid) begin
            action = ACT_LOAD;
        end
    end

    always_comb begin
        load_rec        = '0;
        load_rec.valid  = 1'b1;
        load_rec.rs     = rs;
        load_rec.rt     = rt;
        load_rec.rd     = rd;
        load_rec.imm    = imm;
        load_rec.data_1 = rd_data_1;
        load_rec.data_2 = rd_data_2;
        load_rec.ctl    = dec_ctl;
        load_rec.equal  = (rd_data_1 == rd_data_2);

        idex_d = idex_q;
        unique case (action)
            ACT_LOAD:   idex_d = load_rec;
            ACT_BUBBLE: idex_d = '0;
            ACT_HOLD:   idex_d = idex_q;
            default:    idex_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Nothing is accepted while reset is held.
    assign bus.in_ready   = rst_n && (bus.flush || (!bus.ex_stall && !hazard));
    assign bus.hazard     = hazard;

    assign bus.ex_valid   = idex_q.valid;
    assign bus.ex_rs      = idex_q.rs;
    assign bus.ex_rt      = idex_q.rt;
    assign bus.ex_rd      = idex_q.rd;
    assign bus.ex_imm     = idex_q.imm;
    assign bus.ex_data_1  = idex_q.data_1;
    assign bus.ex_data_2  = idex_q.data_2;
    assign bus.ex_ctl     = idex_q.ctl.ex;
    assign bus.m_ctl      = idex_q.ctl.m;
    assign bus.wb_ctl     = idex_q.ctl.wb;
    assign bus.ex_illegal = idex_q.ctl.illegal;
    assign bus.ex_equal   = idex_q.equal;
endmodule
